// File: rtl/laplace_aproximado_3.sv
// laplace_aproximado_3: one-cycle approximate 5-point Laplacian edge filter.
module laplace_loa #(
  parameter int N = 8,
  parameter int K = 3
) (
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic [N:0]   o_r
);
  // A K of zero degenerates to an exact adder.
  if (K == 0) begin : g_exact
    assign o_r = {1'b0, i_x} + {1'b0, i_y};
  end else begin : g_loa
    // The low part is ORed; its top bit pair alone predicts the carry into the exact part.
    assign o_r[K-1:0] = i_x[K-1:0] | i_y[K-1:0];
    assign o_r[N:K]   = {1'b0, i_x[N-1:K]} + {1'b0, i_y[N-1:K]} + (N-K+1)'(i_x[K-1] & i_y[K-1]);
  end
endmodule

module laplace_aproximado_3 #(
  parameter int K = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] b,
  input  logic [7:0] d,
  input  logic [7:0] e,
  input  logic [7:0] f,
  input  logic [7:0] h,
  output logic [8:0] s,
  output logic       valid_o
);
  logic [8:0]  w_p1, w_p2;
  logic [9:0]  w_sum4;
  logic [10:0] w_diff, w_mag;
  logic [8:0]  w_res;
  logic [8:0]  r_s;
  logic        r_valid;
  laplace_loa #(.N(8), .K(K)) u_p1 (.i_x(b), .i_y(d), .o_r(w_p1));
  laplace_loa #(.N(8), .K(K)) u_p2 (.i_x(f), .i_y(h), .o_r(w_p2));
  laplace_loa #(.N(9), .K(K)) u_s4 (.i_x(w_p1), .i_y(w_p2), .o_r(w_sum4));
  // Signed difference, magnitude and saturation to a sign flag plus 8-bit magnitude.
  always_comb begin
    w_diff = {1'b0, e, 2'b00} - {1'b0, w_sum4};
    w_mag  = w_diff[10] ? -w_diff : w_diff;
    w_res  = {w_diff[10], |w_mag[10:8] ? 8'hFF : w_mag[7:0]};
  end
  // Result register: loads on valid windows, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) r_s <= w_res;
    end
  end
  assign s       = r_s;
  assign valid_o = r_valid;
endmodule

// File: tb/tb_laplace_aproximado_3.sv
// tb_laplace_aproximado_3: randomized and directed checks against an arithmetic LOA model.
module tb_laplace_aproximado_3;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i = 1'b0;
  logic [7:0] b = '0, d = '0, e = '0, f = '0, h = '0;
  logic [8:0] s;
  logic       valid_o;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_s;

  laplace_aproximado_3 #(.K(3)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i),
    .b(b), .d(d), .e(e), .f(f), .h(h),
    .s(s), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  function automatic int loa(int x, int y);
    int lo, cin;
    lo  = (x % 8) | (y % 8);
    cin = ((x % 8) >= 4 && (y % 8) >= 4) ? 1 : 0;
    return (x / 8 + y / 8 + cin) * 8 + lo;
  endfunction

  function automatic logic [8:0] model(int pb, int pd, int pe, int pf, int ph);
    int diff, m;
    logic [8:0] r;
    diff = 4 * pe - loa(loa(pb, pd), loa(pf, ph));
    m = diff < 0 ? -diff : diff;
    r[8] = diff < 0;
    r[7:0] = m > 255 ? 8'd255 : 8'(m);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] vb, vd, ve, vf, vh);
    @(negedge clk);
    valid_i = v; b = vb; d = vd; e = ve; f = vf; h = vh;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (s !== 9'h000 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: s=%h valid_o=%b, want s=000 valid_o=0", s, valid_o);
    end
    @(negedge clk);
    rst = 1'b0;
    valid_i = 1'b1; b = 8'd0; d = 8'd0; e = 8'd255; f = 8'd0; h = 8'd0;
    @(posedge clk); #1;
    checks++;
    if (s !== 9'h0FF || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_window: s=%h valid_o=%b, want s=0FF valid_o=1", s, valid_o);
    end
    drive(1'b1, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (s !== 9'h000 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_mid_stream: s=%h valid_o=%b, want s=000 valid_o=0", s, valid_o);
    end
    @(negedge clk);
    rst = 1'b0;
    valid_i = 1'b1; b = 8'd0; d = 8'd255; e = 8'd0; f = 8'd255; h = 8'd255;
    @(posedge clk); #1;
    checks++;
    if (s !== model(0, 255, 0, 255, 255) || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_window: s=%h valid_o=%b, want s=%h valid_o=1", s, valid_o, model(0, 255, 0, 255, 255));
    end
  endtask

  task automatic test_patterns();
    logic [7:0] tb_in [9][5];
    logic [8:0] tb_exp [9];
    tb_in[0] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};         tb_exp[0] = 9'h000;
    tb_in[1] = '{8'd8, 8'd8, 8'd8, 8'd8, 8'd8};         tb_exp[1] = 9'h000;
    tb_in[2] = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100}; tb_exp[2] = 9'h10C;
    tb_in[3] = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0};       tb_exp[3] = 9'h0FF;
    tb_in[4] = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd255}; tb_exp[4] = 9'h1FF;
    tb_in[5] = '{8'd0, 8'd0, 8'd63, 8'd0, 8'd0};        tb_exp[5] = 9'h0FC;
    tb_in[6] = '{8'd1, 8'd0, 8'd64, 8'd0, 8'd0};        tb_exp[6] = 9'h0FF;
    tb_in[7] = '{8'd0, 8'd0, 8'd64, 8'd0, 8'd0};        tb_exp[7] = 9'h0FF;
    tb_in[8] = '{8'd4, 8'd4, 8'd0, 8'd0, 8'd0};         tb_exp[8] = 9'h10C;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, tb_in[i][0], tb_in[i][1], tb_in[i][2], tb_in[i][3], tb_in[i][4]);
      @(posedge clk); #1;
      checks++;
      if (s !== tb_exp[i] || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL pattern_%0d: s=%h valid_o=%b, want s=%h valid_o=1", i, s, valid_o, tb_exp[i]);
      end
    end
    exp_s = tb_exp[8];
  endtask

  task automatic test_stream();
    logic v;
    logic [7:0] rb, rd, re, rf, rh;
    for (int i = 0; i < 256; i++) begin
      v  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rb = 8'($urandom); rd = 8'($urandom); re = 8'($urandom);
      rf = 8'($urandom); rh = 8'($urandom);
      drive(v, rb, rd, re, rf, rh);
      if (v) exp_s = model(rb, rd, re, rf, rh);
      @(posedge clk); #1;
      checks++;
      if (s !== exp_s || valid_o !== v) begin
        errors++;
        $display("FAIL stream_%0d: s=%h valid_o=%b, want s=%h valid_o=%b", i, s, valid_o, exp_s, v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q [$];
    logic [7:0] w [5];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 5; j++) w[j] = 8'($urandom_range(0, 255));
      if (i % 4 == 0) w = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
      drive(1'b1, w[0], w[1], w[2], w[3], w[4]);
      exp_q.push_back(model(w[0], w[1], w[2], w[3], w[4]));
      @(posedge clk); #1;
      exp_s = exp_q.pop_front();
      checks++;
      if (s !== exp_s || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back_%0d: s=%h valid_o=%b, want s=%h valid_o=1", i, s, valid_o, exp_s);
      end
    end
    drive(1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    @(posedge clk); #1;
    checks++;
    if (s !== exp_s || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_stream: s=%h valid_o=%b, want s=%h valid_o=0", s, valid_o, exp_s);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
